// File: rtl/btn_evt_pkg.sv
// Shared types and widths for the button event generator.
package btn_evt_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_DOWN, ST_REPEAT} btn_state_t;

    localparam int MS_W = 16;

endpackage

// File: rtl/btn_evt_fsm.sv
// One button channel: edge detect plus press/long/repeat/release FSM.
// Strobes are registered; an edge at cycle k appears as a strobe at cycle k+1.
module btn_evt_fsm
    import btn_evt_pkg::*;
#(
    parameter int LONG_MS   = 1000,
    parameter int REPEAT_MS = 200,
    parameter int REPEAT_EN = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    input  logic tick,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic held
);

    localparam logic [MS_W-1:0] LONG_TH   = MS_W'(LONG_MS);
    localparam logic [MS_W-1:0] REPEAT_TH = MS_W'(REPEAT_MS);

    btn_state_t      state;
    logic            prev;
    logic [MS_W-1:0] ms_cnt;
    logic [MS_W-1:0] ms_inc;
    logic            rise;
    logic            fall;

    assign rise   = btn & ~prev;
    assign fall   = ~btn & prev;
    // Saturating increment; a threshold match always clears the counter first.
    assign ms_inc = (ms_cnt == '1) ? ms_cnt : ms_cnt + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            prev          <= 1'b0;
            ms_cnt        <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            held          <= 1'b0;
        end else begin
            prev          <= btn;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rise) begin
                        press_pulse <= 1'b1;
                        ms_cnt      <= '0;
                        state       <= ST_DOWN;
                        held        <= 1'b1;
                    end
                end
                ST_DOWN: begin
                    // Release wins over a coincident threshold tick.
                    if (fall) begin
                        release_pulse <= 1'b1;
                        state         <= ST_IDLE;
                        held          <= 1'b0;
                    end else if (tick) begin
                        if (ms_inc == LONG_TH) begin
                            long_pulse <= 1'b1;
                            ms_cnt     <= '0;
                            state      <= ST_REPEAT;
                        end else begin
                            ms_cnt <= ms_inc;
                        end
                    end
                end
                ST_REPEAT: begin
                    if (fall) begin
                        release_pulse <= 1'b1;
                        state         <= ST_IDLE;
                        held          <= 1'b0;
                    end else if (tick) begin
                        if (ms_inc == REPEAT_TH) begin
                            repeat_pulse <= (REPEAT_EN != 0);
                            ms_cnt       <= '0;
                        end else begin
                            ms_cnt <= ms_inc;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    held  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/btn_event_gen.sv
// Shared 1 ms tick prescaler feeding N_BTN independent button event channels.
module btn_event_gen
    import btn_evt_pkg::*;
#(
    parameter int N_BTN     = 4,
    parameter int TICK_DIV  = 27000,
    parameter int LONG_MS   = 1000,
    parameter int REPEAT_MS = 200,
    parameter int REPEAT_EN = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] release_pulse,
    output logic [N_BTN-1:0] long_pulse,
    output logic [N_BTN-1:0] repeat_pulse,
    output logic [N_BTN-1:0] held
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    assign tick = (div_cnt == DIV_W'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_evt_fsm #(
            .LONG_MS   (LONG_MS),
            .REPEAT_MS (REPEAT_MS),
            .REPEAT_EN (REPEAT_EN)
        ) u_fsm (
            .clk           (clk),
            .reset         (reset),
            .btn           (btn_in[i]),
            .tick          (tick),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i]),
            .long_pulse    (long_pulse[i]),
            .repeat_pulse  (repeat_pulse[i]),
            .held          (held[i])
        );
    end

endmodule

// File: tb/tb_btn_event_gen.sv
// Directed bench for btn_event_gen: two instances, auto-repeat enabled and disabled.
module tb_btn_event_gen;

    logic       clk;
    logic       reset;
    logic [3:0] btn_in;
    logic [3:0] press_a, release_a, long_a, repeat_a, held_a;
    logic [3:0] press_b, release_b, long_b, repeat_b, held_b;

    int checks;
    int errors;
    int cyc;

    btn_event_gen #(
        .N_BTN(4), .TICK_DIV(10), .LONG_MS(5), .REPEAT_MS(2), .REPEAT_EN(1)
    ) dut_a (
        .clk(clk), .reset(reset), .btn_in(btn_in),
        .press_pulse(press_a), .release_pulse(release_a), .long_pulse(long_a),
        .repeat_pulse(repeat_a), .held(held_a)
    );

    btn_event_gen #(
        .N_BTN(4), .TICK_DIV(10), .LONG_MS(5), .REPEAT_MS(2), .REPEAT_EN(0)
    ) dut_b (
        .clk(clk), .reset(reset), .btn_in(btn_in),
        .press_pulse(press_b), .release_pulse(release_b), .long_pulse(long_b),
        .repeat_pulse(repeat_b), .held(held_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // After step(), cyc counts rising edges since reset release; ticks act at cyc%10==0.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [3:0] ep, input logic [3:0] er,
                              input logic [3:0] el, input logic [3:0] erp, input logic [3:0] eh);
        chk({tag, "/press"},     press_a,   ep);
        chk({tag, "/release"},   release_a, er);
        chk({tag, "/long"},      long_a,    el);
        chk({tag, "/repeat"},    repeat_a,  erp);
        chk({tag, "/held"},      held_a,    eh);
        chk({tag, "/b_press"},   press_b,   ep);
        chk({tag, "/b_release"}, release_b, er);
        chk({tag, "/b_long"},    long_b,    el);
        chk({tag, "/b_repeat"},  repeat_b,  4'b0000);
        chk({tag, "/b_held"},    held_b,    eh);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        reset  = 1'b0;
        btn_in = 4'b0000;

        // 1: reset state, then idle with the tick free-running every 10 cycles
        repeat (3) @(posedge clk);
        #1;
        expect_out("reset", 4'b0, 4'b0, 4'b0, 4'b0, 4'b0);
        reset = 1'b1;
        cyc   = 0;
        while (cyc < 100) begin
            step();
            expect_out("idle", 4'b0, 4'b0, 4'b0, 4'b0, 4'b0);
            chk("tick", {3'b000, dut_a.tick}, {3'b000, (cyc % 10 == 9)});
        end

        // 2: short press on channel 0, high for 20 cycles
        btn_in[0] = 1'b1;
        while (cyc < 125) begin
            step();
            expect_out("short",
                       (cyc == 101) ? 4'b0001 : 4'b0000,
                       (cyc == 121) ? 4'b0001 : 4'b0000,
                       4'b0000, 4'b0000,
                       (cyc >= 101 && cyc <= 120) ? 4'b0001 : 4'b0000);
            if (cyc == 120) btn_in[0] = 1'b0;
        end
        while (cyc < 130) begin
            step();
            expect_out("gap1", 4'b0, 4'b0, 4'b0, 4'b0, 4'b0);
        end

        // 3: long hold on channel 1 for 120 cycles
        btn_in[1] = 1'b1;
        while (cyc < 255) begin
            step();
            expect_out("long",
                       (cyc == 131) ? 4'b0010 : 4'b0000,
                       (cyc == 251) ? 4'b0010 : 4'b0000,
                       (cyc == 180) ? 4'b0010 : 4'b0000,
                       (cyc == 200 || cyc == 220 || cyc == 240) ? 4'b0010 : 4'b0000,
                       (cyc >= 131 && cyc <= 250) ? 4'b0010 : 4'b0000);
            if (cyc == 250) btn_in[1] = 1'b0;
        end
        while (cyc < 260) begin
            step();
            expect_out("gap2", 4'b0, 4'b0, 4'b0, 4'b0, 4'b0);
        end

        // 4: channel 2 released exactly as the 5th tick lands
        btn_in[2] = 1'b1;
        while (cyc < 315) begin
            step();
            expect_out("race",
                       (cyc == 261) ? 4'b0100 : 4'b0000,
                       (cyc == 310) ? 4'b0100 : 4'b0000,
                       4'b0000, 4'b0000,
                       (cyc >= 261 && cyc <= 309) ? 4'b0100 : 4'b0000);
            if (cyc == 309) btn_in[2] = 1'b0;
        end
        while (cyc < 320) begin
            step();
            expect_out("gap3", 4'b0, 4'b0, 4'b0, 4'b0, 4'b0);
        end

        // 5: all four channels rise together; channels 0..2 drop later, 3 stays held
        btn_in = 4'b1111;
        while (cyc < 400) begin
            step();
            expect_out("all",
                       (cyc == 321) ? 4'b1111 : 4'b0000,
                       (cyc == 396) ? 4'b0111 : 4'b0000,
                       (cyc == 370) ? 4'b1111 : 4'b0000,
                       (cyc == 390) ? 4'b1111 : 4'b0000,
                       (cyc >= 321 && cyc <= 395) ? 4'b1111 :
                       (cyc >= 396) ? 4'b1000 : 4'b0000);
            if (cyc == 395) btn_in[2:0] = 3'b000;
        end

        // 6: reset while channel 3 is in REPEAT, release with the button still high
        reset = 1'b0;
        #1;
        expect_out("rst_async", 4'b0, 4'b0, 4'b0, 4'b0, 4'b0);
        repeat (3) begin
            step();
            expect_out("rst_hold", 4'b0, 4'b0, 4'b0, 4'b0, 4'b0);
        end
        reset = 1'b1;
        cyc   = 0;
        while (cyc < 14) begin
            step();
            expect_out("post_rst",
                       (cyc == 1) ? 4'b1000 : 4'b0000,
                       (cyc == 13) ? 4'b1000 : 4'b0000,
                       4'b0000, 4'b0000,
                       (cyc >= 1 && cyc <= 12) ? 4'b1000 : 4'b0000);
            if (cyc == 12) btn_in[3] = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
